led_rate_scheduler: RTL and testbench

Schedules the LED blink counter on the DE-board. Debounces the four push-buttons, selects the step rate (1/2/4/8) and runs a pause-able tick scheduler. Emits a one-cycle `TICK` that the LED counter uses as its increment enable, so that counter no longer needs a free-running divider of its own.

---
 rtl/led_ctrl_pkg.sv | 21 ++
 rtl/key_debounce.sv | 46 ++++
 rtl/led_rate_scheduler.sv | 131 +++++++++++++
 tb/tb_led_rate_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED rate scheduler.
// States, step codes and LEDG bit positions.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] STEP_1 = 4'd1;
    localparam logic [3:0] STEP_2 = 4'd2;
    localparam logic [3:0] STEP_4 = 4'd4;
    localparam logic [3:0] STEP_8 = 4'd8;

    localparam int LEDG_STEP_LSB = 0;
    localparam int LEDG_STEP_MSB = 3;
    localparam int LEDG_HOLD     = 6;
    localparam int LEDG_RUN      = 7;

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchronizer, debounce counter, press event.
// Ports: CLOCK_50, RESET, key_n (raw, active-low), level, press (1 cycle).
module key_debounce
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            level <= 1'b1;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            meta  <= key_n;
            sync  <= meta;
            press <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level flips; a press is the 1->0 flip only.
                cnt   <= '0;
                level <= sync;
                press <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_rate_scheduler.sv
// Tick scheduler for the LED counter: debounced keys pick the step,
// SW[9] pauses. Ports: CLOCK_50, RESET, KEY, SW -> TICK, STEP, LEDG.
module led_rate_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int TERMINAL        = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACC_W           = 26
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic       TICK,
    output logic [3:0] STEP,
    output logic [7:0] LEDG
);

    localparam logic [ACC_W-1:0] TERM = ACC_W'(TERMINAL);

    logic [3:0] key_level;
    logic [3:0] key_press;
    logic       hold_m;
    logic       hold_s;
    logic       load;
    logic [3:0] step_sel;

    state_t           state, state_n;
    logic [3:0]       step, step_n;
    logic [ACC_W-1:0] acc, acc_n, acc_sum;
    logic             tick_q, tick_n;

    logic unused_in;
    assign unused_in = ^{SW[8:0], key_level};

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .CLOCK_50(CLOCK_50),
            .RESET   (RESET),
            .key_n   (KEY[i]),
            .level   (key_level[i]),
            .press   (key_press[i])
        );
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            hold_m <= 1'b0;
            hold_s <= 1'b0;
        end else begin
            hold_m <= SW[9];
            hold_s <= hold_m;
        end
    end

    // Lowest key index wins on simultaneous presses.
    always_comb begin
        load     = |key_press;
        step_sel = STEP_1;
        priority case (1'b1)
            key_press[0]: step_sel = STEP_1;
            key_press[1]: step_sel = STEP_2;
            key_press[2]: step_sel = STEP_4;
            key_press[3]: step_sel = STEP_8;
            default:      step_sel = STEP_1;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state  <= STOP;
            step   <= '0;
            acc    <= '0;
            tick_q <= 1'b0;
        end else begin
            state  <= state_n;
            step   <= step_n;
            acc    <= acc_n;
            tick_q <= tick_n;
        end
    end

    always_comb begin
        state_n = state;
        step_n  = step;
        acc_n   = acc;
        tick_n  = 1'b0;
        acc_sum = acc + {{(ACC_W-4){1'b0}}, step};
        if (load) begin
            step_n = step_sel;
        end
        unique case (state)
            STOP: begin
                if (load) begin
                    state_n = hold_s ? HOLD : RUN;
                end
            end
            RUN: begin
                // Remainder is kept so the long-term rate is exact.
                if (acc_sum >= TERM) begin
                    acc_n  = acc_sum - TERM;
                    tick_n = !hold_s;
                end else begin
                    acc_n = acc_sum;
                end
                if (hold_s) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (!hold_s) begin
                    state_n = RUN;
                end
            end
            default: state_n = STOP;
        endcase
    end

    always_comb begin
        LEDG = '0;
        LEDG[LEDG_STEP_MSB:LEDG_STEP_LSB] = step;
        LEDG[LEDG_HOLD] = (state == HOLD);
        LEDG[LEDG_RUN]  = (state == RUN);
    end

    assign TICK = tick_q;
    assign STEP = step;

endmodule

// File: tb/tb_led_rate_scheduler.sv
// Bench for led_rate_scheduler with TERMINAL=16 and a TERMINAL=15 copy.
// Expected steps and tick intervals are queued, then popped on output.
module tb_led_rate_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic [3:0] key15 = 4'hF;
    logic [9:0] sw = '0;
    logic [9:0] sw15 = '0;
    logic       tick, tick15;
    logic [3:0] step, step15;
    logic [7:0] ledg, ledg15;

    int n_chk = 0;
    int n_err = 0;
    int exp_q[$];
    logic [3:0] step_q[$];

    always #5 clk = ~clk;

    led_rate_scheduler #(
        .TERMINAL(16), .DEBOUNCE_CYCLES(4), .ACC_W(8)
    ) dut (
        .CLOCK_50(clk), .RESET(rst), .KEY(key), .SW(sw),
        .TICK(tick), .STEP(step), .LEDG(ledg)
    );

    led_rate_scheduler #(
        .TERMINAL(15), .DEBOUNCE_CYCLES(4), .ACC_W(8)
    ) dut15 (
        .CLOCK_50(clk), .RESET(rst), .KEY(key15), .SW(sw15),
        .TICK(tick15), .STEP(step15), .LEDG(ledg15)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until the next TICK; 65 means none within the bound.
    task automatic wait_tick(bit t15, output int n);
        n = 65;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            if ((t15 ? tick15 : tick) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic sync_tick(string tag, bit t15);
        int n;
        wait_tick(t15, n);
        chk({tag, "_sync"}, 32'(n <= 64), 1);
    endtask

    task automatic tick_intervals(string tag, bit t15, int cnt);
        int n;
        for (int i = 0; i < cnt; i++) begin
            wait_tick(t15, n);
            chk($sformatf("%s_iv%0d", tag, i), n, exp_q.pop_front());
        end
    endtask

    task automatic no_tick(string tag, int cyc_n);
        int seen = 0;
        for (int i = 0; i < cyc_n; i++) begin
            @(posedge clk);
            #1;
            if (tick !== 1'b0) seen++;
        end
        chk(tag, seen, 0);
    endtask

    task automatic press_keys(string tag, bit t15,
                              logic [3:0] mask, logic [3:0] exp);
        logic [3:0] prev, cur;
        int lat;
        bit seen;
        step_q.push_back(exp);
        prev = t15 ? step15 : step;
        cur = prev;
        if (t15) key15 &= ~mask;
        else key &= ~mask;
        lat = 0;
        seen = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            cur = t15 ? step15 : step;
            if (!seen && cur != prev) begin
                seen = 1'b1;
                lat = n;
            end
            if (n == 10) begin
                if (t15) key15 |= mask;
                else key |= mask;
            end
            if (seen && n >= 10) break;
        end
        if (t15) key15 |= mask;
        else key |= mask;
        chk({tag, "_lat"}, lat, 7);
        chk({tag, "_step"}, 32'(cur), 32'(step_q.pop_front()));
        cyc(10);
    endtask

    initial begin
        int n;
        cyc(3);
        rst = 1'b0;

        // Idle after reset
        no_tick("rst_notick", 100);
        chk("rst_step", step, 0);
        chk("rst_ledg", ledg, 0);

        // Rate 1
        press_keys("k0", 1'b0, 4'b0001, 4'd1);
        chk("run_led", ledg[7], 1);
        chk("run_ledg_lo", ledg[6:4], 0);
        exp_q.push_back(16);
        exp_q.push_back(16);
        sync_tick("r1", 1'b0);
        tick_intervals("r1", 1'b0, 2);

        // Rate 8
        press_keys("k3", 1'b0, 4'b1000, 4'd8);
        repeat (4) exp_q.push_back(2);
        sync_tick("r8", 1'b0);
        tick_intervals("r8", 1'b0, 4);

        // Bounce shorter than the debounce window
        for (int i = 0; i < 5; i++) begin
            key[1] = 1'b0;
            cyc(3);
            key[1] = 1'b1;
            cyc(1);
        end
        cyc(8);
        chk("bounce_step", step, 8);
        press_keys("k1", 1'b0, 4'b0010, 4'd2);
        repeat (2) exp_q.push_back(8);
        sync_tick("r2", 1'b0);
        tick_intervals("r2", 1'b0, 2);

        // Simultaneous KEY[2] and KEY[3]
        press_keys("k23", 1'b0, 4'b1100, 4'd4);
        repeat (3) exp_q.push_back(4);
        sync_tick("r4", 1'b0);
        tick_intervals("r4", 1'b0, 3);

        // TERMINAL=15 with step 4: ticks at +4,+8,+12,+15,+19...
        press_keys("t15", 1'b1, 4'b0100, 4'd4);
        wait_tick(1'b1, n);
        chk("t15_phase", n, 2);
        exp_q.push_back(4);
        exp_q.push_back(4);
        exp_q.push_back(4);
        exp_q.push_back(3);
        exp_q.push_back(4);
        exp_q.push_back(4);
        exp_q.push_back(4);
        exp_q.push_back(3);
        tick_intervals("t15", 1'b1, 8);

        // Hold with acc frozen at 10, step 1
        press_keys("h_k0", 1'b0, 4'b0001, 4'd1);
        sync_tick("h1", 1'b0);
        cyc(7);
        sw[9] = 1'b1;
        no_tick("hold_notick", 50);
        chk("hold_led", ledg[6], 1);
        chk("hold_run_led", ledg[7], 0);
        press_keys("h_k1", 1'b0, 4'b0010, 4'd2);
        no_tick("hold_notick2", 20);
        chk("hold_step", step, 2);
        sw[9] = 1'b0;
        wait_tick(1'b0, n);
        chk("resume_lat", n, 6);
        chk("resume_led", ledg[7], 1);
        exp_q.push_back(8);
        exp_q.push_back(8);
        tick_intervals("resume", 1'b0, 2);

        // Asynchronous reset while TICK is high
        wait_tick(1'b0, n);
        chk("pre_rst_tick", tick, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tick", tick, 0);
        chk("mid_rst_step", step, 0);
        chk("mid_rst_ledg", ledg, 0);
        cyc(2);
        rst = 1'b0;
        no_tick("post_rst_notick", 30);
        chk("post_rst_step", step, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
